// File: rtl/regfile_op_sequencer_pkg.sv
// Shared definitions for the register-file op sequencer: default widths,
// opcode encodings, FSM state encodings and a small flag helper.
package regfile_op_sequencer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  // Opcodes carried on cmd_op
  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_RD  = 3'd7;

  // Sequencer FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  // Zero flag of a result word
  function automatic logic is_zero(input logic [DATA_W_DEF-1:0] value);
    return (value == {DATA_W_DEF{1'b0}});
  endfunction

endpackage

// File: rtl/regfile_op_sequencer_if.sv
// Bundle of the command, response and register-file port signals around the
// sequencer. The slave modport is the sequencer itself; the master modport is
// the environment around it (decode logic plus the register file).
interface regfile_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_ra;
  logic [ADDR_W-1:0] cmd_rb;
  logic [DATA_W-1:0] cmd_imm;

  logic [ADDR_W-1:0] RA_addr;
  logic [ADDR_W-1:0] RB_addr;
  logic [DATA_W-1:0] RA_data;
  logic [DATA_W-1:0] RB_data;
  logic [ADDR_W-1:0] WR_addr;
  logic [DATA_W-1:0] WR_data;
  logic              WE;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_carry;
  logic              rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    input  cmd_ready,
    input  RA_addr, RB_addr, WR_addr, WR_data, WE,
    output RA_data, RB_data,
    input  rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    output cmd_ready,
    output RA_addr, RB_addr, WR_addr, WR_data, WE,
    input  RA_data, RB_data,
    output rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

endinterface

// File: rtl/regfile_op_sequencer_alu16.sv
// Purely combinational ALU used in the EXEC state. Produces a DATA_W-bit
// result plus a carry; carry is only meaningful for ADD and SUB (not-borrow)
// and is forced to zero for every other operation.
module regfile_alu16
  import regfile_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum_s;

  // Select the operation; the extra top bit holds the carry out
  always_comb begin
    sum_s = {(DATA_W+1){1'b0}};
    case (op)
      OP_LDI:  sum_s = {1'b0, imm};
      OP_MOV:  sum_s = {1'b0, op_a};
      OP_ADD:  sum_s = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB:  sum_s = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
      OP_AND:  sum_s = {1'b0, op_a & op_b};
      OP_OR:   sum_s = {1'b0, op_a | op_b};
      OP_XOR:  sum_s = {1'b0, op_a ^ op_b};
      OP_RD:   sum_s = {1'b0, op_a};
      default: sum_s = {1'b0, op_a};
    endcase
  end

  assign result = sum_s[DATA_W-1:0];
  assign carry  = sum_s[DATA_W];

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command-driven initiator for the 8x16 register file. One command at a time
// walks IDLE -> READ -> EXEC -> WRITE; operands are captured at the end of
// READ, so a destination that aliases a source is harmless. All outputs are
// registered; WE and rsp_valid are single-cycle pulses in WRITE.
module regfile_op_sequencer
  import regfile_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_op_sequencer_if.slave bus
);

  logic [1:0]        state_r;
  logic [2:0]        op_r;
  logic [ADDR_W-1:0] rd_r;
  logic [DATA_W-1:0] imm_r;
  logic [DATA_W-1:0] op_a_r;
  logic [DATA_W-1:0] op_b_r;

  logic              cmd_ready_r;
  logic [ADDR_W-1:0] ra_addr_r;
  logic [ADDR_W-1:0] rb_addr_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              we_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_carry_r;
  logic              rsp_zero_r;

  logic [DATA_W-1:0] alu_result_s;
  logic              alu_carry_s;

  regfile_alu16 #(.DATA_W(DATA_W)) u_alu (
    .op     (op_r),
    .op_a   (op_a_r),
    .op_b   (op_b_r),
    .imm    (imm_r),
    .result (alu_result_s),
    .carry  (alu_carry_s)
  );

  // Sequencer FSM: command latch, operand capture, result and write-back pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= 3'd0;
      rd_r        <= {ADDR_W{1'b0}};
      imm_r       <= {DATA_W{1'b0}};
      op_a_r      <= {DATA_W{1'b0}};
      op_b_r      <= {DATA_W{1'b0}};
      cmd_ready_r <= 1'b1;
      ra_addr_r   <= {ADDR_W{1'b0}};
      rb_addr_r   <= {ADDR_W{1'b0}};
      wr_addr_r   <= {ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
      we_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      rsp_carry_r <= 1'b0;
      rsp_zero_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            op_r        <= bus.cmd_op;
            rd_r        <= bus.cmd_rd;
            imm_r       <= bus.cmd_imm;
            // Read addresses are presented for the whole READ cycle
            ra_addr_r   <= bus.cmd_ra;
            rb_addr_r   <= bus.cmd_rb;
            cmd_ready_r <= 1'b0;
            state_r     <= ST_READ;
          end
        end
        ST_READ: begin
          op_a_r  <= bus.RA_data;
          op_b_r  <= bus.RB_data;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_data_r  <= alu_result_s;
          rsp_carry_r <= alu_carry_s;
          rsp_zero_r  <= is_zero(alu_result_s);
          rsp_valid_r <= 1'b1;
          // RD reports only; the write port keeps its previous value
          if (op_r != OP_RD) begin
            we_r      <= 1'b1;
            wr_addr_r <= rd_r;
            wr_data_r <= alu_result_s;
          end else begin
            we_r      <= 1'b0;
          end
          state_r <= ST_WRITE;
        end
        ST_WRITE: begin
          we_r        <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          we_r        <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.RA_addr   = ra_addr_r;
  assign bus.RB_addr   = rb_addr_r;
  assign bus.WR_addr   = wr_addr_r;
  assign bus.WR_data   = wr_data_r;
  assign bus.WE        = we_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_carry = rsp_carry_r;
  assign bus.rsp_zero  = rsp_zero_r;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Self-checking bench for regfile_op_sequencer: a register-file model drives
// the read data, a table of commands with hand-computed results feeds a
// scoreboard queue, and a negedge monitor pops and compares every response.
module tb_regfile_op_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_op_sequencer_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_op_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file model: combinational reads, write on the rising edge
  logic [15:0] rf [8];
  assign bus.RA_data = rf[bus.RA_addr];
  assign bus.RB_data = rf[bus.RB_addr];
  always @(posedge clk) if (bus.WE === 1'b1) rf[bus.WR_addr] <= bus.WR_data;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
    logic [15:0] data;
    logic        carry;
    logic        zero;
  } vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] data;
    logic        carry;
    logic        zero;
  } exp_t;

  exp_t        sb_q[$];
  vec_t        vecs[14];
  int          checks = 0;
  int          errors = 0;
  int          rsp_count = 0;
  int          we_pulses = 0;
  int          cyc = 0;
  logic [2:0]  last_wr_addr = 3'd0;
  logic [15:0] last_wr_data = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                              input logic [2:0] rb, input logic [15:0] imm, input logic [15:0] data,
                              input logic carry, input logic zero);
    vec_t v;
    v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm;
    v.data = data; v.carry = carry; v.zero = zero;
    return v;
  endfunction

  // Expected write-port behaviour: RD leaves the previous address/data in place
  task automatic push_exp(input vec_t v);
    exp_t e;
    e.we = (v.op != 3'd7);
    if (e.we) begin
      last_wr_addr = v.rd;
      last_wr_data = v.data;
    end
    e.wr_addr = last_wr_addr;
    e.wr_data = last_wr_data;
    e.data    = v.data;
    e.carry   = v.carry;
    e.zero    = v.zero;
    sb_q.push_back(e);
  endtask

  task automatic drive(input vec_t v);
    bus.cmd_op  = v.op;
    bus.cmd_rd  = v.rd;
    bus.cmd_ra  = v.ra;
    bus.cmd_rb  = v.rb;
    bus.cmd_imm = v.imm;
  endtask

  // Response monitor: pop the scoreboard on each rsp_valid pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.WE === 1'b1) we_pulses++;
      if (bus.rsp_valid === 1'b1) begin
        rsp_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_data",  {16'h0, bus.rsp_data}, {16'h0, e.data});
          chk("rsp_carry", {31'h0, bus.rsp_carry}, {31'h0, e.carry});
          chk("rsp_zero",  {31'h0, bus.rsp_zero}, {31'h0, e.zero});
          chk("we",        {31'h0, bus.WE}, {31'h0, e.we});
          chk("wr_addr",   {29'h0, bus.WR_addr}, {29'h0, e.wr_addr});
          chk("wr_data",   {16'h0, bus.WR_data}, {16'h0, e.wr_data});
        end
      end else if (bus.WE !== 1'b0) begin
        chk("stray_we", {31'h0, bus.WE}, 32'd0);
      end
    end
  end

  // Single command: check acceptance, then the 3-cycle response latency
  task automatic issue(input vec_t v);
    int n;
    bit got;
    chk("ready_before_cmd", {31'h0, bus.cmd_ready}, 32'd1);
    drive(v);
    bus.cmd_valid = 1'b1;
    push_exp(v);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_imm = 16'($urandom);
    bus.cmd_ra  = 3'($urandom);
    bus.cmd_rb  = 3'($urandom);
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid === 1'b1) got = 1'b1;
    end
    chk("latency", n, 32'd3);
    @(negedge clk);
    #1;
  endtask

  // Drain the scoreboard and wait for the sequencer to be ready again
  task automatic settle();
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", sb_q.size(), 32'd0);
    for (int k = 0; k < 10 && bus.cmd_ready !== 1'b1; k++) @(negedge clk);
    #1;
  endtask

  initial begin
    vec_t b2b[3];
    int   acc_cyc[3];
    int   idx;
    int   rc;
    int   wp;

    // Hand-computed expected results, applied in order
    vecs[0]  = mk(3'd0, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0); // LDI r3
    vecs[1]  = mk(3'd0, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0); // LDI r1
    vecs[2]  = mk(3'd0, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0); // LDI r2
    vecs[3]  = mk(3'd2, 3'd4, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b1, 1'b1); // ADD wraps
    vecs[4]  = mk(3'd7, 3'd0, 3'd4, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1); // RD r4
    vecs[5]  = mk(3'd3, 3'd5, 3'd2, 3'd1, 16'h0000, 16'h0002, 1'b0, 1'b0); // SUB borrow
    vecs[6]  = mk(3'd6, 3'd1, 3'd1, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1); // XOR alias
    vecs[7]  = mk(3'd1, 3'd7, 3'd3, 3'd0, 16'h0000, 16'h1234, 1'b0, 1'b0); // MOV
    vecs[8]  = mk(3'd4, 3'd0, 3'd3, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b1); // AND
    vecs[9]  = mk(3'd5, 3'd6, 3'd3, 3'd5, 16'h0000, 16'h1236, 1'b0, 1'b0); // OR
    vecs[10] = mk(3'd3, 3'd0, 3'd3, 3'd3, 16'h0000, 16'h0000, 1'b1, 1'b1); // SUB no borrow
    vecs[11] = mk(3'd2, 3'd2, 3'd3, 3'd7, 16'h0000, 16'h2468, 1'b0, 1'b0); // ADD
    vecs[12] = mk(3'd7, 3'd0, 3'd1, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1); // RD r1
    vecs[13] = mk(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1); // LDI zero

    bus.cmd_valid = 1'b0;
    drive(mk(3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0, 1'b0));

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'd1);
    chk("rst_we",        {31'h0, bus.WE}, 32'd0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("rst_ra_addr",   {29'h0, bus.RA_addr}, 32'd0);
    chk("rst_wr_data",   {16'h0, bus.WR_data}, 32'd0);
    chk("rst_rsp_data",  {16'h0, bus.rsp_data}, 32'd0);
    chk("rst_flags",     {30'h0, bus.rsp_carry, bus.rsp_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < 14; i++) issue(vecs[i]);
    settle();

    // Back-to-back: cmd_valid held high, second command reads first's result
    b2b[0] = mk(3'd0, 3'd6, 3'd0, 3'd0, 16'h00AA, 16'h00AA, 1'b0, 1'b0);
    b2b[1] = mk(3'd2, 3'd6, 3'd6, 3'd6, 16'h0000, 16'h0154, 1'b0, 1'b0);
    b2b[2] = mk(3'd1, 3'd1, 3'd6, 3'd0, 16'h0000, 16'h0154, 1'b0, 1'b0);
    rc = rsp_count;
    idx = 0;
    @(negedge clk);
    drive(b2b[0]);
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 40 && idx < 3; t++) begin
      if (bus.cmd_ready === 1'b1) begin
        acc_cyc[idx] = cyc;
        push_exp(b2b[idx]);
        @(posedge clk);
        #1;
        idx++;
        if (idx < 3) drive(b2b[idx]);
        else bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_accepts", idx, 32'd3);
    chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], 32'd4);
    chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], 32'd4);
    settle();
    chk("b2b_rsp_count", rsp_count - rc, 32'd3);

    // Reset during EXEC of ADD r6: no write, command discarded
    wp = we_pulses;
    drive(mk(3'd2, 3'd6, 3'd1, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b0));
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_we",        {31'h0, bus.WE}, 32'd0);
    chk("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    last_wr_addr = 3'd0;
    last_wr_data = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", {31'h0, bus.cmd_ready}, 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("midrst_no_we", we_pulses - wp, 32'd0);
    issue(mk(3'd7, 3'd0, 3'd6, 3'd0, 16'h0000, 16'h0154, 1'b0, 1'b0)); // r6 unchanged
    settle();

    // cmd_valid while busy must be ignored
    rc = rsp_count;
    drive(mk(3'd0, 3'd5, 3'd0, 3'd0, 16'h5555, 16'h5555, 1'b0, 1'b0));
    bus.cmd_valid = 1'b1;
    push_exp(mk(3'd0, 3'd5, 3'd0, 3'd0, 16'h5555, 16'h5555, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    bus.cmd_imm = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("busy_ready_low", {31'h0, bus.cmd_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_rsp_count", rsp_count - rc, 32'd1);
    issue(mk(3'd7, 3'd0, 3'd5, 3'd0, 16'h0000, 16'h5555, 1'b0, 1'b0));
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
